// File: rtl/ps2_key_rx_pkg.sv
// ps2_key_rx_pkg: shared PS/2 byte codes and frame receiver state encoding
package ps2_key_rx_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;
endpackage

// File: rtl/ps2_key_rx_frame_rx.sv
// ps2_key_rx_frame_rx: synchronizes PS/2 pins and deserializes 11-bit frames; PS2_FILTER_EN adds a ps2_clk glitch filter
module ps2_key_rx_frame_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_ok_o,
  output logic       err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] cs_q, ds_q;
  logic clk_s, prev_q, fall, data;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, byte_q, byte_d;
  logic par_q, par_d, ok_q, ok_d, err_q, err_d, tout;
  logic [TW-1:0] to_q, to_d;
  // Pin synchronizers; lines idle high so reset to 1 to avoid a phantom edge
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cs_q <= '1;
      ds_q <= '1;
    end else begin
      cs_q <= {cs_q[SYNC_STAGES-2:0], ps2_clk_i};
      ds_q <= {ds_q[SYNC_STAGES-2:0], ps2_data_i};
    end
`ifdef PS2_FILTER_EN
  logic filt_q;
  logic [2:0] fcnt_q;
  // Follow the synced clock only after it has disagreed for 8 consecutive samples
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (cs_q[SYNC_STAGES-1] != filt_q) begin
      fcnt_q <= fcnt_q + 3'd1;
      if (fcnt_q == 3'd7) filt_q <= cs_q[SYNC_STAGES-1];
    end else begin
      fcnt_q <= '0;
    end
  assign clk_s = filt_q;
`else
  assign clk_s = cs_q[SYNC_STAGES-1];
`endif
  assign fall = prev_q & ~clk_s;
  assign data = ds_q[SYNC_STAGES-1];
  assign tout = (state_q != S_IDLE) && !fall && (to_q >= TO_LAST);
  // Frame state and output registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      byte_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= clk_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      to_q    <= to_d;
      byte_q  <= byte_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  // Next-state: shift bits on each falling edge, validate stop and parity, abort on timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    byte_d  = byte_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    to_d    = (fall || state_q == S_IDLE) ? '0 : (to_q == TO_LAST ? to_q : to_q + 1'b1);
    case (state_q)
      S_IDLE:   if (fall && !data) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
                end
      S_DATA:   if (fall) begin
                  sr_d    = {data, sr_q[7:1]};
                  cnt_d   = cnt_q + 3'd1;
                  state_d = cnt_q == 3'd7 ? S_PARITY : S_DATA;
                end
      S_PARITY: if (fall) begin
                  par_d   = data;
                  state_d = S_STOP;
                end
      S_STOP:   if (fall) begin
                  state_d = S_IDLE;
                  ok_d    = data & (^{sr_q, par_q});
                  err_d   = ~ok_d;
                  byte_d  = ok_d ? sr_q : byte_q;
                end
    endcase
    if (tout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end
  assign byte_o    = byte_q;
  assign byte_ok_o = ok_q;
  assign err_o     = err_q;
endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver tracking make/break/E0 prefixes and holding the pressed scan code
module ps2_key_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] key_stroke_o,
  output logic       key_ext_o,
  output logic       key_valid_o,
  output logic       key_release_o,
  output logic       frame_err_o
);
  logic [7:0] rx_byte, stroke_q, stroke_d;
  logic rx_ok, rx_err;
  logic brk_q, brk_d, ext_q, ext_d, kext_q, kext_d;
  logic valid_q, valid_d, rel_q, rel_d, ferr_q;
  ps2_key_rx_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .byte_o    (rx_byte),
    .byte_ok_o (rx_ok),
    .err_o     (rx_err)
  );
  // Prefix flags and registered key outputs
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      stroke_q <= '0;
      kext_q   <= 1'b0;
      valid_q  <= 1'b0;
      rel_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      stroke_q <= stroke_d;
      kext_q   <= kext_d;
      valid_q  <= valid_d;
      rel_q    <= rel_d;
      ferr_q   <= rx_err;
    end
  // Decode accepted bytes; a break only clears the held key if it names that same key
  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    stroke_d = stroke_q;
    kext_d   = kext_q;
    valid_d  = 1'b0;
    rel_d    = 1'b0;
    if (rx_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_ok) begin
      if (rx_byte == PS2_BREAK) brk_d = 1'b1;
      else if (rx_byte == PS2_EXT) ext_d = 1'b1;
      else begin
        brk_d   = 1'b0;
        ext_d   = 1'b0;
        valid_d = ~brk_q;
        rel_d   = brk_q;
        if (!brk_q) begin
          stroke_d = rx_byte;
          kext_d   = ext_q;
        end else if ({ext_q, rx_byte} == {kext_q, stroke_q}) begin
          stroke_d = '0;
          kext_d   = 1'b0;
        end
      end
    end
  end
  assign key_stroke_o  = stroke_q;
  assign key_ext_o     = kext_q;
  assign key_valid_o   = valid_q;
  assign key_release_o = rel_q;
  assign frame_err_o   = ferr_q;
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: PS/2 BFM driving directed and random frames against a key-state reference model
module tb_ps2_key_rx;
  localparam int S  = 2;
  localparam int TO = 200;
  localparam int HP = 20;
  logic clk, rst_n, ps2_clk, ps2_data;
  logic [7:0] key_stroke;
  logic key_ext, key_valid, key_release, frame_err;
  int cyc, fall_cyc, pulse_cyc, n_val, n_rel, n_err, n_mx, total, pass;
  logic m_brk, m_ext, m_kext;
  logic [7:0] m_code;
  logic [7:0] pool [6] = '{8'hF0, 8'hE0, 8'h1C, 8'h1B, 8'h75, 8'h2B};

  ps2_key_rx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .key_stroke_o(key_stroke), .key_ext_o(key_ext), .key_valid_o(key_valid),
    .key_release_o(key_release), .frame_err_o(frame_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters sampled on the falling clock edge
  always @(negedge clk) if (rst_n) begin
    if (key_valid) n_val++;
    if (key_release) n_rel++;
    if (frame_err) n_err++;
    if ($countones({key_valid, key_release, frame_err}) > 1) n_mx++;
    if (key_valid || key_release || frame_err) pulse_cyc = cyc;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HP / 2);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HP);
    ps2_clk = 1'b1;
    wait_cyc(HP / 2);
  endtask

  // reference: the key-level effect of one received byte
  task automatic model(input logic [7:0] b, input logic bad, output int ev, output int er, output int ee);
    ev = 0; er = 0; ee = 0;
    if (bad) begin
      ee = 1; m_brk = 0; m_ext = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      if (!m_brk) begin
        ev = 1; m_code = b; m_kext = m_ext;
      end else begin
        er = 1;
        if (b == m_code && m_ext == m_kext) begin m_code = 0; m_kext = 0; end
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic bad);
    int v0, r0, e0, ev, er, ee;
    v0 = n_val; r0 = n_rel; e0 = n_err;
    model(b, bad, ev, er, ee);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad);
    send_bit(1'b1);
    chk($sformatf("stroke[%h]", b), key_stroke, m_code);
    chk($sformatf("ext[%h]", b), key_ext, m_kext);
    chk($sformatf("valid[%h]", b), n_val - v0, ev);
    chk($sformatf("release[%h]", b), n_rel - r0, er);
    chk($sformatf("err[%h]", b), n_err - e0, ee);
  endtask

  initial begin
    int e0;
    cyc = 0; n_val = 0; n_rel = 0; n_err = 0; n_mx = 0; total = 0; pass = 0; pulse_cyc = 0;
    m_brk = 0; m_ext = 0; m_kext = 0; m_code = 0;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(3);
    chk("rst_stroke", key_stroke, 0);
    chk("rst_ext", key_ext, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_release", key_release, 0);
    chk("rst_err", frame_err, 0);
    rst_n = 1'b1;
    wait_cyc(5);
    frame(8'h1C, 0);
    chk("latency", pulse_cyc - fall_cyc, S + 2);
    frame(8'hF0, 0); frame(8'h1C, 0);
    frame(8'hE0, 0); frame(8'h75, 0);
    frame(8'hE0, 0); frame(8'hF0, 0); frame(8'h75, 0);
    frame(8'h1C, 0); frame(8'h1B, 0); frame(8'hF0, 0); frame(8'h1C, 0);
    frame(8'h23, 1); frame(8'h2B, 0);
    frame(8'hF0, 0);
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_cyc(TO - 50);
    chk("timeout_early", n_err - e0, 0);
    wait_cyc(100);
    chk("timeout_err", n_err - e0, 1);
    m_brk = 0; m_ext = 0;
    frame(8'h1B, 0);
    send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stroke", key_stroke, 0);
    chk("midrst_ext", key_ext, 0);
    m_brk = 0; m_ext = 0; m_kext = 0; m_code = 0;
    ps2_data = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(4);
    frame(8'h42, 0);
    for (int k = 0; k < 40; k++) frame(pool[$urandom_range(5, 0)], $urandom_range(7, 0) == 0);
    chk("mutex", n_mx, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
